// File: rtl/reflect_coeff_q_if.sv
// Stream bundle for the reflection-coefficient quantiser: raw k_tmp in,
// scaled/biased k and b out, plus frame bookkeeping (idx, last, unstable, clr).
interface reflect_coeff_q_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int ORDER = 10
);
  localparam int IDX_W = $clog2(ORDER);

  logic                    clr;
  logic signed [IN_W-1:0]  k_tmp;
  logic                    v;
  logic                    in_ready;
  logic [15:0]             scale;
  logic signed [OUT_W-1:0] k;
  logic signed [OUT_W-1:0] b;
  logic                    vout;
  logic                    out_ready;
  logic [IDX_W-1:0]        idx;
  logic                    last;
  logic                    unstable;

  modport master (
    output clr, k_tmp, v, scale, out_ready,
    input  in_ready, k, b, vout, idx, last, unstable
  );

  modport slave (
    input  clr, k_tmp, v, scale, out_ready,
    output in_ready, k, b, vout, idx, last, unstable
  );
endinterface

// File: rtl/reflect_coeff_q.sv
// Three-stage pipeline that bandwidth-expands a raw reflection coefficient
// (k = sat(round(k_tmp*scale >> SHIFT))) and derives b = sat((k_tmp+2) >>> 2).
module reflect_coeff_q #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int ORDER = 10
) (
  input logic              clk,
  input logic              rst_n,
  reflect_coeff_q_if.slave bus
);
  localparam int IDX_W = $clog2(ORDER);
  localparam int P_W   = IN_W + 17;
  localparam int R_W   = IN_W + 18;
  localparam int B_W   = IN_W + 1;

  localparam logic signed [R_W-1:0] RND   = R_W'(1) << (SHIFT - 1);
  localparam logic signed [R_W-1:0] K_MAX = (R_W'(1) << (OUT_W - 1)) - R_W'(1);
  localparam logic signed [R_W-1:0] K_MIN = -(R_W'(1) << (OUT_W - 1));
  localparam logic signed [B_W-1:0] B_MAX = (B_W'(1) << (OUT_W - 1)) - B_W'(1);
  localparam logic signed [B_W-1:0] B_MIN = -(B_W'(1) << (OUT_W - 1));
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(ORDER - 1);

  logic                    stall;
  logic                    in_ready;
  logic                    accept;
  logic                    xfer;

  logic                    v1;
  logic                    v2;
  logic                    v3;
  logic signed [P_W-1:0]   p1;
  logic signed [B_W-1:0]   bp1;
  logic signed [R_W-1:0]   r2;
  logic signed [B_W-1:0]   bs2;
  logic signed [OUT_W-1:0] k_q;
  logic signed [OUT_W-1:0] b_q;
  logic [IDX_W-1:0]        cnt;
  logic                    unstable_q;

  logic signed [R_W-1:0]   kq;
  logic                    k_pos;
  logic                    k_neg;
  logic                    b_pos;
  logic                    b_neg;
  logic signed [OUT_W-1:0] k_sat;
  logic signed [OUT_W-1:0] b_sat;

  // One global stall freezes every stage; ready is held low while in reset.
  assign stall    = v3 && !bus.out_ready;
  assign in_ready = rst_n && !stall;
  assign accept   = bus.v && in_ready;
  assign xfer     = v3 && bus.out_ready;

  // k at or below -1.0 counts as unstable even when it fits exactly.
  assign kq    = r2 >>> SHIFT;
  assign k_pos = kq > K_MAX;
  assign k_neg = kq <= K_MIN;
  assign b_pos = bs2 > B_MAX;
  assign b_neg = bs2 < B_MIN;
  assign k_sat = k_pos ? K_MAX[OUT_W-1:0] : (k_neg ? K_MIN[OUT_W-1:0] : kq[OUT_W-1:0]);
  assign b_sat = b_pos ? B_MAX[OUT_W-1:0] : (b_neg ? B_MIN[OUT_W-1:0] : bs2[OUT_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      p1  <= '0;
      bp1 <= '0;
      r2  <= '0;
      bs2 <= '0;
      k_q <= '0;
      b_q <= '0;
    end else if (!stall) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) begin
        p1  <= P_W'(bus.k_tmp) * P_W'($signed({1'b0, bus.scale}));
        bp1 <= B_W'(bus.k_tmp) + B_W'(2);
      end
      if (v1) begin
        r2  <= R_W'(p1) + RND;
        bs2 <= bp1 >>> 2;
      end
      if (v2) begin
        k_q <= k_sat;
        b_q <= b_sat;
      end
    end
  end

  // clr beats both the index advance and a new saturation in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      unstable_q <= 1'b0;
    end else if (bus.clr) begin
      cnt        <= '0;
      unstable_q <= 1'b0;
    end else begin
      if (xfer)
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + IDX_W'(1);
      if (!stall && v2 && (k_pos || k_neg))
        unstable_q <= 1'b1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.k        = k_q;
  assign bus.b        = b_q;
  assign bus.vout     = v3;
  assign bus.idx      = cnt;
  assign bus.last     = (cnt == LAST_IDX);
  assign bus.unstable = unstable_q;
endmodule

// File: doc/reflect_coeff_q.md
REFLECT_COEFF_Q -- requirements
Module: reflect_coeff_q

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning signed input width of the raw reflection coefficient k_tmp.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning signed width of outputs k and b.
REQ-003 The block SHALL have parameter SHIFT, default 15, meaning fractional bits of the scale factor (Q-format of k).
REQ-004 The block SHALL have parameter ORDER, default 10, meaning coefficients per frame (LPC order, >=2).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-007 The block SHALL have port clr, input, 1, synchronous frame clear.
REQ-008 The block SHALL have port k_tmp, input, IN_W signed, raw coefficient.
REQ-009 The block SHALL have port v, input, 1, k_tmp valid.
REQ-010 The block SHALL have port in_ready, output, 1, input accepted when v && in_ready.
REQ-011 The block SHALL have port scale, input, 16 unsigned, bandwidth-expansion factor; 0x7FF8 is nominal.
REQ-012 The block SHALL have ports k and b, output, OUT_W signed each, scaled and biased coefficients.
REQ-013 The block SHALL have port vout, output, 1, k/b/idx/last valid.
REQ-014 The block SHALL have port out_ready, input, 1, downstream accept; transfer when vout && out_ready.
REQ-015 The block SHALL have port idx, output, ceil(log2(ORDER)), coefficient index within frame.
REQ-016 The block SHALL have port last, output, 1, high with vout when idx == ORDER-1.
REQ-017 The block SHALL have port unstable, output, 1, sticky flag: some k in this frame saturated (|k| >= 1.0).

Function
REQ-018 Datapath SHALL be a 3-stage pipeline: S1 product and b pre-add, S2 rounding add and b shift, S3 shift, saturate, register outputs; latency 3 cycles accept-to-vout with no stall.
REQ-019 S1 SHALL compute p = k_tmp * scale as signed IN_W+17-bit product (scale zero-extended) and bp = k_tmp + 2 at IN_W+1 bits; scale SHALL be sampled on the accepting cycle.
REQ-020 S2 SHALL compute r = p + 2^(SHIFT-1) without overflow and bs = bp >>> 2 (arithmetic).
REQ-021 S3 SHALL set k = saturate(r >>> SHIFT) and b = saturate(bs) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; no wrap-around.
REQ-022 Stall SHALL be global: stall = vout && !out_ready; while stalled every stage, output and counter holds and in_ready = 0; otherwise in_ready = 1.
REQ-023 Stage valid bits SHALL advance one stage per non-stalled cycle; v low inserts a bubble; k/b/idx/last SHALL hold their values while vout = 0.
REQ-024 Index counter SHALL advance on each output transfer, wrap ORDER-1 -> 0; idx and last SHALL reflect the counter value at transfer.
REQ-025 unstable SHALL set at S3 load when k saturated positive, or when r >>> SHIFT <= -2^(OUT_W-1); it stays set until clr or reset.
REQ-026 clr SHALL zero the index counter and unstable next cycle; clr wins over simultaneous advance or set; clr SHALL NOT flush pipeline data.
REQ-027 Back-to-back inputs with out_ready held high SHALL sustain one result per cycle with no lost or duplicated samples.

Reset
REQ-028 While rst_n = 0, all stage valids, vout, last, unstable, counter, k, b and idx SHALL be 0 asynchronously; in_ready SHALL be 0 during reset and 1 the first cycle after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight samples; first output after release SHALL carry idx = 0.

Verification
REQ-030 k_tmp = 0x00004000, scale = 0x7FF8, out_ready = 1 -> 3 cycles later k = 0x3FFC, b = 0x1000, idx = 0, unstable = 0.
REQ-031 k_tmp = 0xFFFFC000, scale = 0x7FF8 -> k = 0xC004, b = 0xF000 (floor rounding on negatives).
REQ-032 k_tmp = 0x00010000, scale = 0x7FF8 -> k = 0x7FFF (saturated), b = 0x4000, unstable = 1 and stays set until clr pulse.
REQ-033 ORDER = 10 back-to-back inputs -> idx 0..9, last only on idx 9, next frame idx 0; clr in same cycle as 5th transfer -> next idx 0.
REQ-034 out_ready low for 4 cycles with 3 samples in flight -> in_ready = 0, k/b/idx frozen, no sample lost or duplicated after release.
REQ-035 rst_n pulsed low with 2 samples in flight -> vout = 0 immediately, both discarded, next accepted sample emerges with idx = 0.
